// File: rtl/vga_pkg.sv
// ----------------------------------------------------------------------------
// vga_pkg : shared types, defaults and helpers for the framebuffer arbiter
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package vga_pkg;

  localparam int AW_DEF   = 15;
  localparam int DW_DEF   = 12;
  localparam int FB_W_DEF = 160;
  localparam int FB_H_DEF = 120;

  // Pixel word packing {R,G,B}, 4 bits each
  localparam int R_HI = 11;
  localparam int R_LO = 8;
  localparam int G_HI = 7;
  localparam int G_LO = 4;
  localparam int B_HI = 3;
  localparam int B_LO = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN_RD = 2'd1,
    CAPTURE = 2'd2,
    WRITE   = 2'd3
  } fb_state_t;

  function automatic logic [23:0] fb_addr(input logic [11:0] x, input logic [11:0] y);
    return 24'(y) * 24'(FB_W_DEF) + 24'(x);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_fb_addr_gen.sv
// ----------------------------------------------------------------------------
// vga_fb_addr_gen : scaled (x,y) to linear framebuffer address with range flag
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module vga_fb_addr_gen #(
  parameter int FB_W = 160,
  parameter int FB_H = 120,
  parameter int AW   = 15
) (
  input  logic [11:0]   x,
  input  logic [11:0]   y,
  output logic [AW-1:0] addr,
  output logic          in_range
);

  localparam logic [11:0] W12    = 12'(FB_W);
  localparam logic [11:0] H12    = 12'(FB_H);
  localparam logic [23:0] SIZE24 = 24'(FB_W * FB_H);

  logic [23:0] y_mul;
  logic [23:0] lin;

  generate
    if (FB_W == 160) begin : g_mul160
      assign y_mul = ({12'd0, y} << 7) + ({12'd0, y} << 5);
    end else begin : g_mul_generic
      assign y_mul = {12'd0, y} * 24'(FB_W);
    end
  endgenerate

  assign lin      = y_mul + {12'd0, x};
  assign in_range = (x < W12) && (y < H12) && (lin < SIZE24);
  assign addr     = in_range ? lin[AW-1:0] : '0;

endmodule

`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
// ----------------------------------------------------------------------------
// vga_fb_arbiter : shares one sync RAM between VGA scanout and a pixel writer
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int FB_W          = FB_W_DEF,
  parameter int FB_H          = FB_H_DEF,
  parameter int SCALE_LOG2    = 2,
  parameter int AW            = AW_DEF,
  parameter int DW            = DW_DEF,
  parameter bit WR_BLANK_ONLY = 1'b0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          P_CLK,
  input  logic [11:0]   XPOS,
  input  logic [11:0]   YPOS,
  input  logic          DISP_ACTIVE,
  input  logic          WR_REQ,
  input  logic [AW-1:0] WR_ADDR,
  input  logic [DW-1:0] WR_DATA,
  output logic          WR_ACK,
  output logic [AW-1:0] MEM_ADDR,
  output logic          MEM_WE,
  output logic [DW-1:0] MEM_WDATA,
  input  logic [DW-1:0] MEM_RDATA,
  output logic [3:0]    Ro,
  output logic [3:0]    Go,
  output logic [3:0]    Bo,
  output logic          FRAME_DONE
);

  localparam logic [AW-1:0] FB_SIZE = AW'(FB_W * FB_H);
  localparam logic [11:0]   LAST_Y  = 12'((FB_H << SCALE_LOG2) - 1);
  localparam logic [11:0]   SUB_MSK = 12'((1 << SCALE_LOG2) - 1);

  fb_state_t     state, next_state;
  logic [11:0]   xs, ys;
  logic [AW-1:0] scan_addr;
  logic          scan_in_range;
  logic          slot, scan_rd, wr_grant;
  logic          oor_q, de_d1, de_d2, de_tick;
  logic [DW-1:0] pix_reg;

  assign xs = XPOS >> SCALE_LOG2;
  assign ys = YPOS >> SCALE_LOG2;

  vga_fb_addr_gen #(
    .FB_W (FB_W),
    .FB_H (FB_H),
    .AW   (AW)
  ) u_addr_gen (
    .x        (xs),
    .y        (ys),
    .addr     (scan_addr),
    .in_range (scan_in_range)
  );

  // Reset gates the grants so a write presented during reset is never acked
  assign slot     = P_CLK && DISP_ACTIVE && ((XPOS & SUB_MSK) == 12'd0);
  assign scan_rd  = slot && scan_in_range && !RST;
  assign wr_grant = WR_REQ && !scan_rd && !RST && (state != WRITE) &&
                    (!WR_BLANK_ONLY || !DISP_ACTIVE);

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  // A write may share the capture cycle: the read word is already on MEM_RDATA
  always_comb begin
    next_state = IDLE;
    MEM_ADDR   = '0;
    MEM_WE     = 1'b0;
    MEM_WDATA  = '0;
    WR_ACK     = 1'b0;
    if (scan_rd) begin
      next_state = SCAN_RD;
      MEM_ADDR   = scan_addr;
    end else if (wr_grant) begin
      next_state = WRITE;
      WR_ACK     = 1'b1;
      MEM_ADDR   = WR_ADDR;
      MEM_WDATA  = WR_DATA;
      MEM_WE     = (WR_ADDR < FB_SIZE);
    end else if (state == SCAN_RD) begin
      next_state = CAPTURE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      oor_q      <= 1'b0;
      pix_reg    <= '0;
      de_d1      <= 1'b0;
      de_d2      <= 1'b0;
      de_tick    <= 1'b0;
      Ro         <= 4'd0;
      Go         <= 4'd0;
      Bo         <= 4'd0;
      FRAME_DONE <= 1'b0;
    end else begin
      oor_q <= slot && !scan_in_range;
      if (state == SCAN_RD) pix_reg <= MEM_RDATA;
      else if (oor_q)       pix_reg <= '0;
      de_d1 <= DISP_ACTIVE;
      de_d2 <= de_d1;
      if (de_d2) begin
        Ro <= pix_reg[R_HI:R_LO];
        Go <= pix_reg[G_HI:G_LO];
        Bo <= pix_reg[B_HI:B_LO];
      end else begin
        Ro <= 4'd0;
        Go <= 4'd0;
        Bo <= 4'd0;
      end
      if (P_CLK) de_tick <= DISP_ACTIVE;
      FRAME_DONE <= P_CLK && de_tick && !DISP_ACTIVE && (YPOS == LAST_Y);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_vga_fb_arbiter : scoreboard bench for the framebuffer arbiter
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_vga_fb_arbiter;

  logic        CLK = 1'b0;
  logic        RST, P_CLK, DISP_ACTIVE, WR_REQ;
  logic [11:0] XPOS, YPOS;
  logic [14:0] WR_ADDR;
  logic [11:0] WR_DATA;
  logic        WR_ACK, MEM_WE, FRAME_DONE;
  logic [14:0] MEM_ADDR;
  logic [11:0] MEM_WDATA, MEM_RDATA;
  logic [3:0]  Ro, Go, Bo;

  logic        b_req, b_ack, b_we, b_fd;
  logic [14:0] b_waddr, b_maddr;
  logic [11:0] b_wdata, b_mwdata, b_rdata;
  logic [3:0]  b_ro, b_go, b_bo;

  logic        pl_en;
  logic [14:0] pl_addr;
  logic [11:0] pl_data;
  logic [11:0] ram     [0:32767];
  logic [11:0] ref_mem [0:32767];

  typedef struct {
    int          due;
    logic [11:0] rgb;
    int          tag;
  } exp_t;
  exp_t exp_q[$];

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [11:0] last_exp = 12'h000;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  always @(posedge CLK) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (MEM_WE) ram[MEM_ADDR] <= MEM_WDATA;
    MEM_RDATA <= ram[MEM_ADDR];
  end

  vga_fb_arbiter u_dut (
    .CLK(CLK), .RST(RST), .P_CLK(P_CLK), .XPOS(XPOS), .YPOS(YPOS),
    .DISP_ACTIVE(DISP_ACTIVE), .WR_REQ(WR_REQ), .WR_ADDR(WR_ADDR),
    .WR_DATA(WR_DATA), .WR_ACK(WR_ACK), .MEM_ADDR(MEM_ADDR), .MEM_WE(MEM_WE),
    .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA), .Ro(Ro), .Go(Go), .Bo(Bo),
    .FRAME_DONE(FRAME_DONE)
  );

  vga_fb_arbiter #(.WR_BLANK_ONLY(1'b1)) u_blank (
    .CLK(CLK), .RST(RST), .P_CLK(P_CLK), .XPOS(XPOS), .YPOS(YPOS),
    .DISP_ACTIVE(DISP_ACTIVE), .WR_REQ(b_req), .WR_ADDR(b_waddr),
    .WR_DATA(b_wdata), .WR_ACK(b_ack), .MEM_ADDR(b_maddr), .MEM_WE(b_we),
    .MEM_WDATA(b_mwdata), .MEM_RDATA(b_rdata), .Ro(b_ro), .Go(b_go), .Bo(b_bo),
    .FRAME_DONE(b_fd)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic preload(input logic [14:0] a, input logic [11:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    ref_mem[a] = d;
    step();
    pl_en = 1'b0;
  endtask

  // Drives one pixel tick and pushes the colour expected 3 cycles later
  task automatic start_tick(input logic [11:0] x, input logic [11:0] y, input logic de, input int tag);
    logic [11:0] xs, ys, e;
    logic [11:0] xv;
    XPOS = x; YPOS = y; DISP_ACTIVE = de; P_CLK = 1'b1;
    xs = x >> 2; ys = y >> 2; xv = x;
    if (de && xv[1:0] == 2'b00)
      last_exp = (xs < 12'd160 && ys < 12'd120) ? ref_mem[int'(ys) * 160 + int'(xs)] : 12'h000;
    e = de ? last_exp : 12'h000;
    exp_q.push_back('{due: cyc + 3, rgb: e, tag: tag});
  endtask

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      step();
      P_CLK = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        checks++;
        if (exp_q[0].due != cyc || {Ro, Go, Bo} !== exp_q[0].rgb) begin
          errors++;
          $display("FAIL pixel tag%0d cyc%0d: got %h want %h", exp_q[0].tag, cyc, {Ro, Go, Bo}, exp_q[0].rgb);
        end
        void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic do_write(input logic [14:0] a, input logic [11:0] d,
                          output bit acked, output bit we, output logic [14:0] ma, output logic [11:0] md);
    WR_REQ = 1'b1; WR_ADDR = a; WR_DATA = d;
    acked = 1'b0; we = 1'b0; ma = '0; md = '0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (WR_ACK) begin
        acked = 1'b1; we = MEM_WE; ma = MEM_ADDR; md = MEM_WDATA;
      end
      @(posedge CLK);
      #1;
      if (acked) break;
    end
    WR_REQ = 1'b0;
    if (acked && a < 15'd19200) ref_mem[a] = d;
  endtask

  task automatic test_reset();
    bit got;
    checks++;
    if ({WR_ACK, MEM_WE, MEM_ADDR, MEM_WDATA, Ro, Go, Bo, FRAME_DONE} !== '0) begin
      errors++;
      $display("FAIL reset_state: got ack%b we%b addr%h wd%h rgb%h fd%b want all 0",
               WR_ACK, MEM_WE, MEM_ADDR, MEM_WDATA, {Ro, Go, Bo}, FRAME_DONE);
    end
    WR_REQ = 1'b1; WR_ADDR = 15'd100; WR_DATA = 12'hABC;
    #1;
    checks++;
    if (WR_ACK !== 1'b0 || MEM_WE !== 1'b0) begin
      errors++;
      $display("FAIL reset_write_drop: got ack%b we%b want 0 0", WR_ACK, MEM_WE);
    end
    step();
    RST = 1'b0;
    #1;
    checks++;
    if ({Ro, Go, Bo} !== 12'h000) begin
      errors++;
      $display("FAIL reset_release_rgb: got %h want 000", {Ro, Go, Bo});
    end
    got = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (WR_ACK) begin got = 1'b1; break; end
      step();
      #1;
    end
    checks++;
    if (!got || MEM_WE !== 1'b1 || MEM_ADDR !== 15'd100) begin
      errors++;
      $display("FAIL reset_reserve: got ack%b we%b addr%0d want ack1 we1 addr100", got, MEM_WE, MEM_ADDR);
    end
    ref_mem[100] = 12'hABC;
    step();
    WR_REQ = 1'b0;
    step();
  endtask

  task automatic test_scanout();
    logic [14:0] want;
    for (int x = 0; x < 8; x++) begin
      start_tick(12'(x), 12'd0, 1'b1, 100 + x);
      #1;
      want = (x % 4 == 0) ? 15'(x / 4) : 15'd0;
      checks++;
      if (MEM_ADDR !== want || MEM_WE !== 1'b0) begin
        errors++;
        $display("FAIL scan_addr x%0d: got addr%0d we%b want addr%0d we0", x, MEM_ADDR, MEM_WE, want);
      end
      run_cycles(4);
    end
  endtask

  task automatic test_collision();
    start_tick(12'd8, 12'd0, 1'b1, 200);
    WR_REQ = 1'b1; WR_ADDR = 15'd2; WR_DATA = 12'hAAA;
    #1;
    checks++;
    if (MEM_WE !== 1'b0 || WR_ACK !== 1'b0 || MEM_ADDR !== 15'd2) begin
      errors++;
      $display("FAIL collide_slot: got we%b ack%b addr%0d want we0 ack0 addr2", MEM_WE, WR_ACK, MEM_ADDR);
    end
    step();
    P_CLK = 1'b0;
    #1;
    checks++;
    if (WR_ACK !== 1'b1 || MEM_WE !== 1'b1 || MEM_ADDR !== 15'd2 || MEM_WDATA !== 12'hAAA) begin
      errors++;
      $display("FAIL collide_write: got ack%b we%b addr%0d wd%h want ack1 we1 addr2 wdAAA",
               WR_ACK, MEM_WE, MEM_ADDR, MEM_WDATA);
    end
    ref_mem[2] = 12'hAAA;
    run_cycles(1);
    WR_REQ = 1'b0;
    run_cycles(2);
    start_tick(12'd8, 12'd0, 1'b1, 201);
    run_cycles(4);
  endtask

  task automatic test_readback();
    bit acked, we;
    logic [14:0] ma;
    logic [11:0] md;
    do_write(15'd161, 12'h00F, acked, we, ma, md);
    checks++;
    if (!acked || !we || ma !== 15'd161 || md !== 12'h00F) begin
      errors++;
      $display("FAIL readback_write: got ack%b we%b addr%0d wd%h want ack1 we1 addr161 wd00F", acked, we, ma, md);
    end
    step();
    start_tick(12'd4, 12'd4, 1'b1, 300);
    run_cycles(4);
  endtask

  task automatic test_boundary();
    bit acked, we;
    logic [14:0] ma;
    logic [11:0] md;
    do_write(15'd19200, 12'h0FF, acked, we, ma, md);
    checks++;
    if (!acked || we !== 1'b0) begin
      errors++;
      $display("FAIL oor_write: got ack%b we%b want ack1 we0", acked, we);
    end
    step();
    start_tick(12'd640, 12'd0, 1'b1, 400);
    #1;
    checks++;
    if (MEM_ADDR !== 15'd0 || MEM_WE !== 1'b0) begin
      errors++;
      $display("FAIL oor_scan_addr: got addr%0d we%b want 0 0", MEM_ADDR, MEM_WE);
    end
    run_cycles(4);
    start_tick(12'd0, 12'd0, 1'b0, 401);
    run_cycles(4);
    start_tick(12'd0, 12'd10, 1'b1, 402);
    run_cycles(4);
    start_tick(12'd640, 12'd10, 1'b0, 403);
    run_cycles(1);
    checks++;
    if (FRAME_DONE !== 1'b0) begin
      errors++;
      $display("FAIL frame_done_midframe: got %b want 0", FRAME_DONE);
    end
    run_cycles(3);
    start_tick(12'd636, 12'd479, 1'b1, 404);
    run_cycles(4);
    start_tick(12'd640, 12'd479, 1'b0, 405);
    run_cycles(1);
    checks++;
    if (FRAME_DONE !== 1'b1) begin
      errors++;
      $display("FAIL frame_done_pulse: got %b want 1", FRAME_DONE);
    end
    run_cycles(1);
    checks++;
    if (FRAME_DONE !== 1'b0) begin
      errors++;
      $display("FAIL frame_done_width: got %b want 0", FRAME_DONE);
    end
    run_cycles(2);
  endtask

  task automatic test_blank_only();
    DISP_ACTIVE = 1'b1; P_CLK = 1'b0;
    b_req = 1'b1; b_waddr = 15'd7; b_wdata = 12'h111;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (b_ack !== 1'b0) begin
        errors++;
        $display("FAIL blank_only_hold k%0d: got ack%b want 0", k, b_ack);
      end
      step();
    end
    DISP_ACTIVE = 1'b0;
    #1;
    checks++;
    if (b_ack !== 1'b1 || b_we !== 1'b1 || b_maddr !== 15'd7) begin
      errors++;
      $display("FAIL blank_only_grant: got ack%b we%b addr%0d want ack1 we1 addr7", b_ack, b_we, b_maddr);
    end
    step();
    b_req = 1'b0;
    step();
  endtask

  initial begin
    RST = 1'b1; P_CLK = 1'b0; XPOS = '0; YPOS = '0; DISP_ACTIVE = 1'b0;
    WR_REQ = 1'b0; WR_ADDR = '0; WR_DATA = '0;
    b_req = 1'b0; b_waddr = '0; b_wdata = '0; b_rdata = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    repeat (3) @(posedge CLK);
    #1;
    test_reset();
    preload(15'd0, 12'hF00);
    preload(15'd1, 12'h0F0);
    preload(15'd2, 12'h555);
    preload(15'd161, 12'h000);
    preload(15'd320, 12'h321);
    preload(15'd19199, 12'h123);
    test_scanout();
    test_collision();
    test_readback();
    test_boundary();
    test_blank_only();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
